// File: rtl/div_sequencer.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready handshakes.
// Division by zero and signed overflow bypass the iteration and respond on the next edge.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] dmag;
    logic            neg_quot;
    logic            neg_rem;
    logic            want_rem;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_next;
    logic [XLEN-1:0] r_next;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    // Negating the most negative value wraps back to itself, which is its correct unsigned magnitude.
    always_comb begin
        is_signed   = ~op[0];
        a_neg       = is_signed & a[XLEN-1];
        b_neg       = is_signed & b[XLEN-1];
        a_mag       = a_neg ? (~a + 1'b1) : a;
        b_mag       = b_neg ? (~b + 1'b1) : b;
        b_zero      = (b == '0);
        ovf         = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        special_res = '0;
        if (b_zero) begin
            special_res = op[1] ? a : '1;
        end else if (ovf) begin
            special_res = op[1] ? '0 : a;
        end
    end

    // One XLEN+1 bit wide trial subtraction per step so a shifted remainder never overflows.
    always_comb begin
        shifted = {rem, quot[XLEN-1]};
        diff    = shifted - {1'b0, dmag};
        q_next  = {quot[XLEN-2:0], ~diff[XLEN]};
        r_next  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        q_fix   = neg_quot ? (~quot + 1'b1) : quot;
        r_fix   = neg_rem ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            count     <= '0;
            rem       <= '0;
            quot      <= '0;
            dmag      <= '0;
            neg_quot  <= 1'b0;
            neg_rem   <= 1'b0;
            want_rem  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        if (b_zero || ovf) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rem      <= '0;
                            quot     <= a_mag;
                            dmag     <= b_mag;
                            neg_quot <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            want_rem <= op[1];
                            count    <= CW'(XLEN);
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= r_next;
                    quot  <= q_next;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result    <= want_rem ? r_fix : q_fix;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level arithmetic model.
module tb_div_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Model: 0 = idle, 1 = computing, 2 = result pending
    int              phase       = 0;
    int              cntdown     = 0;
    int              completions = 0;
    logic [XLEN-1:0] m_result    = '0;
    logic [XLEN-1:0] pend_result = '0;

    typedef struct packed {
        logic [1:0]      o;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
        logic [XLEN-1:0] r;
        logic [7:0]      lat;
    } vec_t;

    vec_t vecs [7] = '{
        '{2'd1, 32'd100,        32'd7,          32'd14,         8'd34},
        '{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   8'd34},
        '{2'd0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   8'd34},
        '{2'd0, 32'd5,          32'd0,          32'hFFFFFFFF,   8'd1},
        '{2'd3, 32'd5,          32'd0,          32'd5,          8'd1},
        '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   8'd1},
        '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'd0,          8'd1}
    };

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Returns {special, selected result} straight from the RV32M arithmetic rules
    function automatic logic [XLEN:0] refModel(input logic [1:0] o, input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic            sp;
        bit              sgn;
        sgn = (o == 2'd0) || (o == 2'd2);
        if (y == '0) begin
            q = '1; r = x; sp = 1'b1;
        end else if (sgn && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
            q = x; r = '0; sp = 1'b1;
        end else if (sgn) begin
            q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); sp = 1'b0;
        end else begin
            q = x / y; r = x % y; sp = 1'b0;
        end
        return {sp, (o >= 2'd2) ? r : q};
    endfunction

    function automatic logic [XLEN-1:0] randOperand(input bit divisor);
        case ($urandom_range(0, 4))
            0:       return divisor ? 32'd0 : 32'h80000000;
            1:       return divisor ? 32'hFFFFFFFF : 32'($urandom_range(0, 1000));
            2:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 0;
            m_result <= '0;
        end else if (flush) begin
            phase <= 0;
        end else begin
            case (phase)
                0: if (in_valid) begin
                    if (refModel(op, a, b)[XLEN]) begin
                        m_result <= refModel(op, a, b)[XLEN-1:0];
                        phase    <= 2;
                    end else begin
                        pend_result <= refModel(op, a, b)[XLEN-1:0];
                        cntdown     <= XLEN + 1;
                        phase       <= 1;
                    end
                end
                1: begin
                    cntdown <= cntdown - 1;
                    if (cntdown == 1) begin
                        m_result <= pend_result;
                        phase    <= 2;
                    end
                end
                2: if (out_ready) begin
                    phase       <= 0;
                    completions <= completions + 1;
                end
                default: phase <= 0;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model in_ready", 32'(in_ready), 32'(phase == 0));
            checkOutput("model busy", 32'(busy), 32'(phase != 0));
            checkOutput("model out_valid", 32'(out_valid), 32'(phase == 2));
            checkOutput("model result", result, m_result);
        end
    end

    // Presents one request from a negedge in IDLE; returns at the negedge after the accept edge
    task automatic applyStimulus(input logic [1:0] o, input logic [XLEN-1:0] x,
                                 input logic [XLEN-1:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int edges, output bit busy_ok);
        edges   = 1;
        busy_ok = 1'b1;
        while (!out_valid && edges < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        if (!out_valid) checkOutput("response timeout", 32'(out_valid), 32'd1);
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic completeResponse();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("in_ready after handshake", 32'(in_ready), 32'd1);
        checkOutput("out_valid after handshake", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int  edges;
        bit  busy_ok;
        bit  saw_valid;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset result", result, 32'd0);
        check_en = 1'b1;
        rst_n    = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            out_ready = (i == 0);
            applyStimulus(vecs[i].o, vecs[i].x, vecs[i].y);
            waitResult(edges, busy_ok);
            checkOutput($sformatf("vec%0d result", i), result, vecs[i].r);
            checkOutput($sformatf("vec%0d latency", i), 32'(edges), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d busy", i), 32'(busy_ok), 32'd1);
            completeResponse();
        end

        // Back-pressure: result must be held while the consumer stalls
        applyStimulus(2'd1, 32'hFFFFFFFF, 32'd1);
        waitResult(edges, busy_ok);
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold result", result, 32'hFFFFFFFF);
            @(negedge clk);
        end
        completeResponse();

        // Flush in the tenth CALC cycle discards the operation
        applyStimulus(2'd1, 32'd1000, 32'd7);
        saw_valid = 1'b0;
        repeat (9) begin
            saw_valid |= out_valid;
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy", 32'(busy), 32'd0);
        checkOutput("flush in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush out_valid", 32'(out_valid | saw_valid), 32'd0);
        checkOutput("flush result kept", result, 32'hFFFFFFFF);

        // Flush beats a simultaneous request in IDLE
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 2'd1;
        a        = 32'd50;
        b        = 32'd5;
        @(posedge clk);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush vs accept busy", 32'(busy), 32'd0);

        applyStimulus(2'd1, 32'd9, 32'd3);
        waitResult(edges, busy_ok);
        checkOutput("post-flush result", result, 32'd3);
        checkOutput("post-flush latency", 32'(edges), 32'd34);
        completeResponse();

        // Asynchronous reset in the middle of CALC
        applyStimulus(2'd0, 32'd12345, 32'd67);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset result", result, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            op        = 2'($urandom_range(0, 3));
            a         = randOperand(1'b0);
            b         = randOperand(1'b1);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("random completions", 32'(completions >= 20), 32'd1);
        checkOutput("drained idle", 32'(in_ready), 32'd1);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
